// File: rtl/i2c_init_sequencer_pkg.sv
// Shared definitions for the I2C init sequencer: op codes, table entry layout,
// FSM state encoding and the default HDMI transmitter init table.
package i2c_seq_pkg;

  localparam int ENTRY_W     = 26;
  localparam int TABLE_DEPTH = 64;
  localparam int OP_LSB      = 24;
  localparam int REG_LSB     = 16;
  localparam int VAL_LSB     = 8;
  localparam int MASK_LSB    = 0;

  typedef enum logic [1:0] {
    OP_WRITE = 2'd0,
    OP_POLL  = 2'd1,
    OP_DELAY = 2'd2,
    OP_END   = 2'd3
  } op_t;

  typedef struct packed {
    op_t        op;
    logic [7:0] reg_addr;
    logic [7:0] val;
    logic [7:0] mask;
  } entry_t;

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_ISSUE,
    S_WAIT_ACC,
    S_WAIT_DONE,
    S_CHECK,
    S_DELAY,
    S_FINISH,
    S_FAIL
  } state_t;

  function automatic logic [ENTRY_W-1:0] make_entry(op_t op, logic [7:0] r,
                                                    logic [7:0] v, logic [7:0] m);
    logic [ENTRY_W-1:0] e;
    e = '0;
    e[OP_LSB +: 2]   = op;
    e[REG_LSB +: 8]  = r;
    e[VAL_LSB +: 8]  = v;
    e[MASK_LSB +: 8] = m;
    return e;
  endfunction

  // Wait for hot-plug/monitor sense, power up, then program the video path.
  function automatic logic [TABLE_DEPTH*ENTRY_W-1:0] hdmi_init_table();
    logic [TABLE_DEPTH*ENTRY_W-1:0] t;
    for (int i = 0; i < TABLE_DEPTH; i++)
      t[i*ENTRY_W +: ENTRY_W] = make_entry(OP_END, 8'h00, 8'h00, 8'h00);
    t[0*ENTRY_W +: ENTRY_W]  = make_entry(OP_POLL,  8'h42, 8'h60, 8'h60);
    t[1*ENTRY_W +: ENTRY_W]  = make_entry(OP_WRITE, 8'h41, 8'h10, 8'h00);
    t[2*ENTRY_W +: ENTRY_W]  = make_entry(OP_DELAY, 8'h00, 8'h01, 8'h00);
    t[3*ENTRY_W +: ENTRY_W]  = make_entry(OP_WRITE, 8'h98, 8'h03, 8'h00);
    t[4*ENTRY_W +: ENTRY_W]  = make_entry(OP_WRITE, 8'h9A, 8'hE0, 8'h00);
    t[5*ENTRY_W +: ENTRY_W]  = make_entry(OP_WRITE, 8'h9C, 8'h30, 8'h00);
    t[6*ENTRY_W +: ENTRY_W]  = make_entry(OP_WRITE, 8'h9D, 8'h61, 8'h00);
    t[7*ENTRY_W +: ENTRY_W]  = make_entry(OP_WRITE, 8'hA2, 8'hA4, 8'h00);
    t[8*ENTRY_W +: ENTRY_W]  = make_entry(OP_WRITE, 8'hA3, 8'hA4, 8'h00);
    t[9*ENTRY_W +: ENTRY_W]  = make_entry(OP_WRITE, 8'hE0, 8'hD0, 8'h00);
    t[10*ENTRY_W +: ENTRY_W] = make_entry(OP_WRITE, 8'hF9, 8'h00, 8'h00);
    t[11*ENTRY_W +: ENTRY_W] = make_entry(OP_WRITE, 8'h15, 8'h00, 8'h00);
    t[12*ENTRY_W +: ENTRY_W] = make_entry(OP_WRITE, 8'h16, 8'h30, 8'h00);
    t[13*ENTRY_W +: ENTRY_W] = make_entry(OP_WRITE, 8'hAF, 8'h06, 8'h00);
    return t;
  endfunction

endpackage

// File: rtl/i2c_init_sequencer_if.sv
// Request/response bundle between the init sequencer and the I2C transaction wrapper.
interface i2c_init_sequencer_if;
  logic [6:0] chip_addr;
  logic [7:0] reg_addr;
  logic [7:0] value;
  logic       enable;
  logic       is_read;
  logic [7:0] data;
  logic       done;
  logic       ack_error;

  modport master (
    output chip_addr, reg_addr, value, enable, is_read,
    input  data, done, ack_error
  );

  modport slave (
    input  chip_addr, reg_addr, value, enable, is_read,
    output data, done, ack_error
  );
endinterface

// File: rtl/i2c_init_rom.sv
// Synchronous command table ROM; one cycle from addr to entry.
module i2c_init_rom
  import i2c_seq_pkg::*;
#(
  parameter int                               ROM_AW = 6,
  parameter logic [(2**ROM_AW)*ENTRY_W-1:0]  TABLE  = hdmi_init_table()
) (
  input  logic               clk,
  input  logic [ROM_AW-1:0]  addr,
  output logic [ENTRY_W-1:0] entry
);

  // Registered table lookup.
  always_ff @(posedge clk) begin
    entry <= TABLE[addr*ENTRY_W +: ENTRY_W];
  end

endmodule

// File: rtl/i2c_init_sequencer.sv
// Walks the init command table and issues one I2C transaction at a time,
// with NACK retry, polled reads and timed delays.
module i2c_init_sequencer
  import i2c_seq_pkg::*;
#(
  parameter logic [6:0]                      CHIP_ADDR  = 7'h39,
  parameter int                              ROM_AW     = 6,
  parameter int                              DELAY_UNIT = 27000,
  parameter int                              MAX_RETRY  = 3,
  parameter int                              POLL_LIMIT = 255,
  parameter logic [(2**ROM_AW)*ENTRY_W-1:0]  TABLE      = hdmi_init_table()
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  i2c_init_sequencer_if.master bus,
  output logic                busy,
  output logic                init_done,
  output logic                error,
  output logic [ROM_AW-1:0]   err_index
);

  localparam int DLY_W = $clog2(255*DELAY_UNIT+1);

  state_t             state, next_state;
  logic [ROM_AW-1:0]  index;
  logic [ENTRY_W-1:0] rom_data;
  entry_t             ent;
  logic [7:0]         retry_cnt, poll_cnt;
  logic [DLY_W-1:0]   dly_cnt;
  logic [7:0]         rd_data;
  logic               nack;
  logic               last_entry, nack_over, poll_miss, poll_over;

  i2c_init_rom #(.ROM_AW(ROM_AW), .TABLE(TABLE)) u_rom (
    .clk   (clk),
    .addr  (index),
    .entry (rom_data)
  );

  // rom_data stays valid for the whole entry because index only moves on advance.
  assign ent        = entry_t'(rom_data);
  assign last_entry = (index == '1);
  assign nack_over  = (int'(retry_cnt) + 1) > MAX_RETRY;
  assign poll_miss  = (ent.op == OP_POLL) && ((rd_data & ent.mask) != (ent.val & ent.mask));
  assign poll_over  = (int'(poll_cnt) + 1) > POLL_LIMIT;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= next_state;
  end

  // Next-state logic; running off the end of the table counts as END.
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:      if (start) next_state = S_FETCH;
      S_FETCH:     next_state = S_DECODE;
      S_DECODE: begin
        case (ent.op)
          OP_WRITE, OP_POLL: next_state = S_ISSUE;
          OP_DELAY:          next_state = S_DELAY;
          default:           next_state = S_FINISH;
        endcase
      end
      S_ISSUE:     if (bus.done) next_state = S_WAIT_ACC;
      S_WAIT_ACC:  if (!bus.done) next_state = S_WAIT_DONE;
      S_WAIT_DONE: if (bus.done) next_state = S_CHECK;
      S_CHECK: begin
        if (nack)           next_state = nack_over ? S_FAIL : S_ISSUE;
        else if (poll_miss) next_state = poll_over ? S_FAIL : S_ISSUE;
        else                next_state = last_entry ? S_FINISH : S_FETCH;
      end
      S_DELAY:     if (dly_cnt == '0) next_state = last_entry ? S_FINISH : S_FETCH;
      S_FINISH:    next_state = S_IDLE;
      S_FAIL:      next_state = S_IDLE;
      default:     next_state = S_IDLE;
    endcase
  end

  // Control registers: table index, retry/poll counters and sticky status.
  always_ff @(posedge clk) begin
    if (reset) begin
      index     <= '0;
      retry_cnt <= '0;
      poll_cnt  <= '0;
      init_done <= 1'b0;
      error     <= 1'b0;
      err_index <= '0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          index     <= '0;
          retry_cnt <= '0;
          poll_cnt  <= '0;
          init_done <= 1'b0;
          error     <= 1'b0;
          err_index <= '0;
        end
        S_CHECK: begin
          if (nack)           retry_cnt <= retry_cnt + 8'd1;
          else if (poll_miss) poll_cnt  <= poll_cnt + 8'd1;
          else begin
            index     <= index + 1'b1;
            retry_cnt <= '0;
            poll_cnt  <= '0;
          end
        end
        S_DELAY:  if (dly_cnt == '0) index <= index + 1'b1;
        S_FINISH: init_done <= 1'b1;
        S_FAIL: begin
          error     <= 1'b1;
          err_index <= index;
        end
        default: ;
      endcase
    end
  end

  // Datapath: capture wrapper response and run the delay countdown.
  always_ff @(posedge clk) begin
    if (state == S_WAIT_DONE && bus.done) begin
      rd_data <= bus.data;
      nack    <= bus.ack_error;
    end
    if (state == S_DECODE)
      dly_cnt <= DLY_W'(int'(ent.val) * DELAY_UNIT);
    else if (state == S_DELAY && dly_cnt != '0)
      dly_cnt <= dly_cnt - 1'b1;
  end

  // Outputs: request fields are only driven while a transaction is in flight.
  always_comb begin
    bus.chip_addr = CHIP_ADDR;
    bus.reg_addr  = 8'h00;
    bus.value     = 8'h00;
    bus.is_read   = 1'b0;
    bus.enable    = 1'b0;
    busy          = (state != S_IDLE);
    if (state == S_ISSUE || state == S_WAIT_ACC || state == S_WAIT_DONE) begin
      bus.reg_addr = ent.reg_addr;
      bus.value    = (ent.op == OP_WRITE) ? ent.val : 8'h00;
      bus.is_read  = (ent.op == OP_POLL);
      bus.enable   = (state == S_ISSUE) && bus.done;
    end
  end

endmodule

// File: tb/tb_i2c_init_sequencer.sv
// Bench for i2c_init_sequencer: behavioural wrapper model plus a scoreboard
// of expected transactions checked by an independent monitor.
module tb_i2c_init_sequencer;
  import i2c_seq_pkg::*;

  localparam int AW       = 6;
  localparam int TBL_BITS = (2**AW)*ENTRY_W;
  // Enable of entry 4 follows the last poll's done rise by 7 cycles of
  // overhead plus the 2*10 delay count.
  localparam int GAP      = 27;

  function automatic logic [TBL_BITS-1:0] build_table();
    logic [TBL_BITS-1:0] t;
    for (int i = 0; i < 2**AW; i++)
      t[i*ENTRY_W +: ENTRY_W] = make_entry(OP_END, 8'h00, 8'h00, 8'h00);
    t[0*ENTRY_W +: ENTRY_W] = make_entry(OP_WRITE, 8'h41, 8'h10, 8'h00);
    t[1*ENTRY_W +: ENTRY_W] = make_entry(OP_WRITE, 8'h98, 8'h03, 8'h00);
    t[2*ENTRY_W +: ENTRY_W] = make_entry(OP_POLL,  8'h42, 8'h60, 8'h60);
    t[3*ENTRY_W +: ENTRY_W] = make_entry(OP_DELAY, 8'h00, 8'h02, 8'h00);
    t[4*ENTRY_W +: ENTRY_W] = make_entry(OP_WRITE, 8'h16, 8'h20, 8'h00);
    return t;
  endfunction

  localparam logic [TBL_BITS-1:0] TBL = build_table();

  logic          clk = 1'b0;
  logic          reset, start;
  logic          busy, init_done, error;
  logic [AW-1:0] err_index;

  i2c_init_sequencer_if bus();

  i2c_init_sequencer #(
    .CHIP_ADDR(7'h39), .ROM_AW(AW), .DELAY_UNIT(10),
    .MAX_RETRY(3), .POLL_LIMIT(4), .TABLE(TBL)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .bus(bus),
    .busy(busy), .init_done(init_done), .error(error), .err_index(err_index)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endfunction

  // Wrapper model: done drops the cycle after enable, returns lat+1 cycles later.
  int         lat      = 3;
  logic       nack_all = 1'b0;
  logic [7:0] rd_q[$];
  logic       mdl_done = 1'b1;
  logic       mdl_ack  = 1'b0;
  logic [7:0] mdl_data = 8'h00;
  logic       mdl_rd   = 1'b0;
  int         mdl_cnt  = 0;

  assign bus.done      = mdl_done;
  assign bus.ack_error = mdl_ack;
  assign bus.data      = mdl_data;

  always @(posedge clk) begin
    if (bus.enable) begin
      mdl_done <= 1'b0;
      mdl_cnt  <= lat;
      mdl_rd   <= bus.is_read;
    end else if (!mdl_done) begin
      if (mdl_cnt == 0) begin
        mdl_done <= 1'b1;
        mdl_ack  <= nack_all;
        if (mdl_rd && rd_q.size() > 0) mdl_data <= rd_q.pop_front();
        else                           mdl_data <= 8'h00;
      end else begin
        mdl_cnt <= mdl_cnt - 1;
      end
    end
  end

  // Scoreboard of expected requests; gap < 0 means no timing check.
  typedef struct {
    logic       is_read;
    logic [7:0] reg_addr;
    logic [7:0] value;
    int         gap;
  } txn_t;

  txn_t exp_q[$];

  task automatic expect_txn(input logic rd, input logic [7:0] r, input logic [7:0] v,
                            input int gap);
    txn_t t;
    t.is_read = rd; t.reg_addr = r; t.value = v; t.gap = gap;
    exp_q.push_back(t);
  endtask

  // Monitor: samples on the falling edge, pops one expectation per enable.
  int   cyc = 0;
  int   rise_cyc = 0;
  logic prev_done = 1'b1;

  always @(negedge clk) begin
    txn_t t;
    cyc++;
    if (bus.done && !prev_done) rise_cyc = cyc;
    prev_done = bus.done;
    if (bus.enable) begin
      check("enable_needs_done", {31'd0, bus.done}, 32'd1);
      check("chip_addr", {25'd0, bus.chip_addr}, 32'h39);
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_enable: got reg 0x%0h, expected no request", bus.reg_addr);
      end else begin
        t = exp_q.pop_front();
        check("is_read", {31'd0, bus.is_read}, {31'd0, t.is_read});
        check("reg_addr", {24'd0, bus.reg_addr}, {24'd0, t.reg_addr});
        if (!t.is_read) check("value", {24'd0, bus.value}, {24'd0, t.value});
        if (t.gap >= 0) check("delay_gap", cyc - rise_cyc, t.gap);
      end
    end
  end

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string name);
    int n = 0;
    while (busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, {31'd0, busy}, 32'd0);
  endtask

  task automatic expect_full_table();
    expect_txn(1'b0, 8'h41, 8'h10, -1);
    expect_txn(1'b0, 8'h98, 8'h03, -1);
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_init_done", {31'd0, init_done}, 32'd0);
    check("rst_error", {31'd0, error}, 32'd0);
    check("rst_err_index", {26'd0, err_index}, 32'd0);
    check("rst_enable", {31'd0, bus.enable}, 32'd0);
    check("rst_is_read", {31'd0, bus.is_read}, 32'd0);
    check("rst_reg_addr", {24'd0, bus.reg_addr}, 32'd0);
    check("rst_value", {24'd0, bus.value}, 32'd0);
    check("rst_chip_addr", {25'd0, bus.chip_addr}, 32'h39);
    reset = 1'b0;

    // Writes, a poll that matches on the third read, a delay, a final write.
    expect_full_table();
    repeat (3) expect_txn(1'b1, 8'h42, 8'h00, -1);
    expect_txn(1'b0, 8'h16, 8'h20, GAP);
    rd_q = '{8'h00, 8'h20, 8'h60};
    pulse_start();
    check("a_busy_after_start", {31'd0, busy}, 32'd1);
    wait_idle(2000, "a_timeout");
    check("a_queue_empty", exp_q.size(), 32'd0);
    check("a_init_done", {31'd0, init_done}, 32'd1);
    check("a_error", {31'd0, error}, 32'd0);

    // Every access NACKed: one issue plus three retries, then error on entry 0.
    nack_all = 1'b1;
    repeat (4) expect_txn(1'b0, 8'h41, 8'h10, -1);
    pulse_start();
    check("b_init_done_cleared", {31'd0, init_done}, 32'd0);
    wait_idle(2000, "b_timeout");
    nack_all = 1'b0;
    check("b_queue_empty", exp_q.size(), 32'd0);
    check("b_error", {31'd0, error}, 32'd1);
    check("b_err_index", {26'd0, err_index}, 32'd0);
    check("b_init_done", {31'd0, init_done}, 32'd0);

    // Poll never matches: five reads, then error on entry 2.
    expect_full_table();
    repeat (5) expect_txn(1'b1, 8'h42, 8'h00, -1);
    rd_q = '{8'h00, 8'h20, 8'h40, 8'h1F, 8'h9F};
    pulse_start();
    check("c_error_cleared", {31'd0, error}, 32'd0);
    wait_idle(2000, "c_timeout");
    check("c_queue_empty", exp_q.size(), 32'd0);
    check("c_error", {31'd0, error}, 32'd1);
    check("c_err_index", {26'd0, err_index}, 32'd2);
    check("c_init_done", {31'd0, init_done}, 32'd0);

    // Reset while the wrapper is mid-transfer, restart, and a start during busy.
    lat = 20;
    expect_txn(1'b0, 8'h41, 8'h10, -1);
    pulse_start();
    begin
      int n = 0;
      while (!bus.enable && n < 50) begin
        @(negedge clk);
        n++;
      end
      check("d_first_enable_seen", {31'd0, bus.enable}, 32'd1);
    end
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("d_rst_busy", {31'd0, busy}, 32'd0);
    check("d_rst_enable", {31'd0, bus.enable}, 32'd0);
    check("d_rst_reg_addr", {24'd0, bus.reg_addr}, 32'd0);
    check("d_rst_error", {31'd0, error}, 32'd0);
    check("d_wrapper_still_busy", {31'd0, bus.done}, 32'd0);
    expect_full_table();
    expect_txn(1'b1, 8'h42, 8'h00, -1);
    expect_txn(1'b0, 8'h16, 8'h20, GAP);
    rd_q = '{8'h60};
    pulse_start();
    repeat (30) @(negedge clk);
    check("d_busy_before_restart", {31'd0, busy}, 32'd1);
    pulse_start();
    wait_idle(3000, "d_timeout");
    check("d_queue_empty", exp_q.size(), 32'd0);
    check("d_init_done", {31'd0, init_done}, 32'd1);
    check("d_error", {31'd0, error}, 32'd0);

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
